// File: rtl/muller_c_phase_monitor.sv
// Four-phase handshake observer for a Muller C-element: synchronizes a/b/c, counts
// completed rise+fall cycles and latches the first protocol violation.
// Optional build macro MULLER_MON_TIMEOUT_EN enables the SETTLE timeout (code 10).
module muller_c_phase_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int SETTLE      = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             c_a_i,
    input  logic             c_b_i,
    input  logic             c_out_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic             done_pulse_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [1:0]       err_code_o
);

    typedef enum logic [2:0] {
        S_IDLE0  = 3'd0,
        S_ARM_UP = 3'd1,
        S_HIGH   = 3'd2,
        S_ARM_DN = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    localparam logic [1:0] E_NONE = 2'b00;
    localparam logic [1:0] E_UNIL = 2'b01;
    localparam logic [1:0] E_TOUT = 2'b10;
    localparam logic [1:0] E_WDRW = 2'b11;

    logic [SYNC_STAGES-1:0] r_a_sync, r_b_sync, r_c_sync;
    logic                   w_sa, w_sb, w_sc;
    logic                   w_up_ok, w_dn_ok, w_up_legal, w_dn_legal;
    logic                   r_up_prev, r_dn_prev;
    state_t                 r_state, w_state_nxt;
    logic                   w_done;
    logic [1:0]             w_err_code;
    logic                   w_timeout;
    logic                   w_busy_nxt;
    logic [CNT_W-1:0]       r_count;
    logic                   r_pulse, r_busy, r_err;
    logic [1:0]             r_code;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_a_sync  <= '0;
            r_b_sync  <= '0;
            r_c_sync  <= '0;
            r_up_prev <= 1'b0;
            r_dn_prev <= 1'b0;
        end else begin
            r_a_sync  <= {r_a_sync[SYNC_STAGES-2:0], c_a_i};
            r_b_sync  <= {r_b_sync[SYNC_STAGES-2:0], c_b_i};
            r_c_sync  <= {r_c_sync[SYNC_STAGES-2:0], c_out_i};
            r_up_prev <= w_up_ok;
            r_dn_prev <= w_dn_ok;
        end
    end

    assign w_sa       = r_a_sync[SYNC_STAGES-1];
    assign w_sb       = r_b_sync[SYNC_STAGES-1];
    assign w_sc       = r_c_sync[SYNC_STAGES-1];
    assign w_up_ok    = w_sa & w_sb;
    assign w_dn_ok    = ~w_sa & ~w_sb;
    // Consensus seen last cycle still legalises an output edge (synchronizer skew).
    assign w_up_legal = w_up_ok | r_up_prev;
    assign w_dn_legal = w_dn_ok | r_dn_prev;

`ifdef MULLER_MON_TIMEOUT_EN
    logic [7:0] r_timer;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            r_timer <= '0;
        else if ((w_state_nxt == S_ARM_UP || w_state_nxt == S_ARM_DN) && w_state_nxt != r_state)
            r_timer <= '0;
        else if (r_state == S_ARM_UP || r_state == S_ARM_DN)
            r_timer <= r_timer + 8'd1;
    end

    // Timer reads SETTLE-1 in the SETTLE-th armed cycle, so ERR lands SETTLE cycles after entry.
    assign w_timeout = (r_timer == 8'(SETTLE - 1));
`else
    assign w_timeout = (SETTLE < 0);
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            r_state <= S_IDLE0;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_err_code  = E_NONE;
        if (clr_i) begin
            w_state_nxt = w_sc ? S_HIGH : S_IDLE0;
        end else begin
            unique case (r_state)
                S_IDLE0: begin
                    if (w_sc) begin
                        if (w_up_legal) begin
                            w_state_nxt = S_HIGH;
                        end else begin
                            w_state_nxt = S_ERR;
                            w_err_code  = E_UNIL;
                        end
                    end else if (w_up_ok) begin
                        w_state_nxt = S_ARM_UP;
                    end
                end
                S_ARM_UP: begin
                    if (w_sc) begin
                        w_state_nxt = S_HIGH;
                    end else if (!w_up_ok) begin
                        w_state_nxt = S_ERR;
                        w_err_code  = E_WDRW;
                    end else if (w_timeout) begin
                        w_state_nxt = S_ERR;
                        w_err_code  = E_TOUT;
                    end
                end
                S_HIGH: begin
                    if (!w_sc) begin
                        if (w_dn_legal) begin
                            w_state_nxt = S_IDLE0;
                            w_done      = 1'b1;
                        end else begin
                            w_state_nxt = S_ERR;
                            w_err_code  = E_UNIL;
                        end
                    end else if (w_dn_ok) begin
                        w_state_nxt = S_ARM_DN;
                    end
                end
                S_ARM_DN: begin
                    if (!w_sc) begin
                        w_state_nxt = S_IDLE0;
                        w_done      = 1'b1;
                    end else if (!w_dn_ok) begin
                        w_state_nxt = S_ERR;
                        w_err_code  = E_WDRW;
                    end else if (w_timeout) begin
                        w_state_nxt = S_ERR;
                        w_err_code  = E_TOUT;
                    end
                end
                default: w_state_nxt = S_ERR;
            endcase
        end
    end

    always_comb begin
        w_busy_nxt = (w_state_nxt == S_ARM_UP) || (w_state_nxt == S_HIGH) ||
                     (w_state_nxt == S_ARM_DN);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_count <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= E_NONE;
        end else if (clr_i) begin
            r_count <= '0;
            r_pulse <= 1'b0;
            r_busy  <= w_busy_nxt;
            r_err   <= 1'b0;
            r_code  <= E_NONE;
        end else begin
            r_pulse <= w_done;
            r_busy  <= w_busy_nxt;
            if (w_done && !(&r_count))
                r_count <= r_count + 1'b1;
            if (w_err_code != E_NONE && !r_err) begin
                r_err  <= 1'b1;
                r_code <= w_err_code;
            end
        end
    end

    assign cycle_count_o = r_count;
    assign done_pulse_o  = r_pulse;
    assign busy_o        = r_busy;
    assign err_o         = r_err;
    assign err_code_o    = r_code;

endmodule

// File: tb/tb_muller_c_phase_monitor.sv
// Directed bench for muller_c_phase_monitor: a 16-bit counter instance and a 4-bit
// counter instance share the same stimulus; the latter is only checked for saturation.
module tb_muller_c_phase_monitor;

    logic        clk = 1'b0;
    logic        rst, a, b, c, clr;
    logic [15:0] cnt;
    logic        done, busy, err;
    logic [1:0]  code;
    logic [3:0]  cnt4;
    logic        done4, busy4, err4;
    logic [1:0]  code4;

    int n_chk  = 0;
    int n_fail = 0;
    int np     = 0;
    int np4    = 0;
    int base, base4;

    always #5 clk = ~clk;

    muller_c_phase_monitor #(.SYNC_STAGES(2), .CNT_W(16), .SETTLE(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .c_a_i(a), .c_b_i(b), .c_out_i(c), .clr_i(clr),
        .cycle_count_o(cnt), .done_pulse_o(done), .busy_o(busy), .err_o(err),
        .err_code_o(code));

    muller_c_phase_monitor #(.SYNC_STAGES(2), .CNT_W(4), .SETTLE(4)) dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .c_a_i(a), .c_b_i(b), .c_out_i(c), .clr_i(clr),
        .cycle_count_o(cnt4), .done_pulse_o(done4), .busy_o(busy4), .err_o(err4),
        .err_code_o(code4));

    always @(negedge clk) begin
        if (done)  np++;
        if (done4) np4++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    // One legal four-phase cycle; the pulse is expected 9 edges after a,b rise.
    task automatic do_cycle();
        a = 1'b1; b = 1'b1;
        step(2);
        c = 1'b1;
        step(2);
        chk("busy_arm_up", 32'(busy), 32'd1);
        a = 1'b0; b = 1'b0;
        step(2);
        c = 1'b0;
        step(2);
        chk("pulse_before", 32'(done), 32'd0);
        step(1);
        chk("pulse_high", 32'(done), 32'd1);
        step(1);
        chk("pulse_after", 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; a = 1'b0; b = 1'b0; c = 1'b0; clr = 1'b0;
        step(2);
        chk("rst_cnt",  32'(cnt),  32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err",  32'(err),  32'd0);
        chk("rst_code", 32'(code), 32'd0);
        rst = 1'b0;
        step(2);

        base = np;
        repeat (3) do_cycle();
        chk("fp_cnt",    32'(cnt),     32'd3);
        chk("fp_pulses", 32'(np-base), 32'd3);
        chk("fp_err",    32'(err),     32'd0);
        chk("fp_busy",   32'(busy),    32'd0);

        // Output rises with only one input high.
        a = 1'b1; b = 1'b0;
        step(4);
        c = 1'b1;
        step(2);
        chk("unil_early", 32'(err), 32'd0);
        step(1);
        chk("unil_err",  32'(err),  32'd1);
        chk("unil_code", 32'(code), 32'd1);
        chk("unil_busy", 32'(busy), 32'd0);
        chk("unil_cnt",  32'(cnt),  32'd3);
        a = 1'b0; c = 1'b0;
        step(4);
        pulse_clr();
        chk("clr1_err",  32'(err),  32'd0);
        chk("clr1_code", 32'(code), 32'd0);
        chk("clr1_cnt",  32'(cnt),  32'd0);

        // Inputs agree high, output never follows.
        a = 1'b1; b = 1'b1;
        step(3);
        chk("to_busy", 32'(busy), 32'd1);
`ifdef MULLER_MON_TIMEOUT_EN
        step(3);
        chk("to_early", 32'(err), 32'd0);
        step(1);
        chk("to_err",  32'(err),  32'd1);
        chk("to_code", 32'(code), 32'd2);
        chk("to_busy_after", 32'(busy), 32'd0);
`else
        step(100);
        chk("noto_err",  32'(err),  32'd0);
        chk("noto_busy", 32'(busy), 32'd1);
`endif
        a = 1'b0; b = 1'b0;
        step(4);
        pulse_clr();
        chk("clr2_err", 32'(err), 32'd0);
        chk("clr2_cnt", 32'(cnt), 32'd0);

        // Consensus withdrawn before the output rises.
        a = 1'b1; b = 1'b1;
        step(3);
        b = 1'b0;
        step(2);
        chk("wd_early", 32'(err), 32'd0);
        step(1);
        chk("wd_err",  32'(err),  32'd1);
        chk("wd_code", 32'(code), 32'd3);
        a = 1'b0;
        step(4);
        pulse_clr();
        chk("clr3_err",  32'(err),  32'd0);
        chk("clr3_cnt",  32'(cnt),  32'd0);
        chk("clr3_busy", 32'(busy), 32'd0);
        do_cycle();
        chk("post_clr_cnt", 32'(cnt), 32'd1);

        // Consensus and output change in the same synchronized cycle.
        a = 1'b1; b = 1'b1; c = 1'b1;
        step(3);
        chk("same_up_busy", 32'(busy), 32'd1);
        chk("same_up_err",  32'(err),  32'd0);
        a = 1'b0; b = 1'b0; c = 1'b0;
        step(3);
        chk("same_dn_done", 32'(done), 32'd1);
        chk("same_dn_cnt",  32'(cnt),  32'd2);
        chk("same_dn_busy", 32'(busy), 32'd0);
        chk("same_dn_err",  32'(err),  32'd0);

        // Saturation of the 4-bit counter.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        chk("sat_rst_cnt", 32'(cnt4), 32'd0);
        base4 = np4;
        repeat (17) do_cycle();
        chk("sat_cnt4",    32'(cnt4),      32'd15);
        chk("sat_pulses4", 32'(np4-base4), 32'd17);
        chk("sat_err4",    32'(err4),      32'd0);
        chk("sat_cnt16",   32'(cnt),       32'd17);

        // Asynchronous reset while waiting in ARM_DN with count 5.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        repeat (5) do_cycle();
        a = 1'b1; b = 1'b1;
        step(2);
        c = 1'b1;
        step(2);
        a = 1'b0; b = 1'b0;
        step(4);
        chk("armdn_busy", 32'(busy), 32'd1);
        chk("armdn_cnt",  32'(cnt),  32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cnt",  32'(cnt),  32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_err",  32'(err),  32'd0);
        chk("arst_code", 32'(code), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        a = 1'b1; b = 1'b1; c = 1'b1;
        step(1);
        rst = 1'b0;
        step(4);
        chk("rel_busy", 32'(busy), 32'd1);
        chk("rel_err",  32'(err),  32'd0);
        chk("rel_cnt",  32'(cnt),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
